sm_mem_arbiter: RTL and testbench
=================================

// Module: sm_mem_arbiter
// PURPOSE
//  Round-robin arbiter that shares one single-port SM data memory among the N_CORES SP cores of an SM.
//  Sits between the SP-core array (per-core addr/data/we/q) and the memory macro.
//  Serialises accesses one at a time, returns read data and a done pulse to the winning core.
// PARAMETERS
//  N_CORES   8   number of requesting SP cores (2..16)
//  AW        16  address width
//  DW        16  data width
//  MEM_LAT   1   memory read latency in cycles, mem_en cycle to mem_q valid (1..4)
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-low reset (0 = in reset)
//  en         in   N_CORES    core enable mask; disabled cores are never granted
//  req        in   N_CORES    level request per core; hold until done
//  req_we     in   N_CORES    1=write, 0=read; sampled with req
//  req_addr   in   N_CORES*AW packed addresses, core i at [i*AW +: AW]
//  req_data   in   N_CORES*DW packed write data, core i at [i*DW +: DW]
//  gnt        out  N_CORES    one-hot, winner of the current transaction
//  done       out  N_CORES    one-cycle pulse to the winner at completion
//  rdata      out  DW         read data; valid while done is high
//  busy       out  1          transaction in flight or any enabled request pending
//  mem_en     out  1          memory access strobe
//  mem_we     out  1          memory write enable, qualified by mem_en
//  mem_addr   out  AW         memory address
//  mem_data   out  DW         memory write data
//  mem_q      in   DW         memory read data
// BEHAVIOUR
//  Reset (async assert, sync release):
//   state=IDLE, rr_ptr=0.
//   gnt, done, rdata, mem_en, mem_we, mem_addr, mem_data and busy are all 0.
//   In-flight transaction is dropped without a done pulse.
//   mem_en falls immediately on reset assertion.
//  FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except busy.
//  IDLE:
//   - Candidates are cand = req & en.
//   - If cand != 0: winner = first set bit searching up from rr_ptr, wrapping N_CORES-1 -> 0.
//   - Latch winner idx, req_we, req_addr and req_data. Set gnt[idx]. Go to ISSUE.
//   - Else stay in IDLE.
//  ISSUE (exactly 1 cycle):
//   - mem_en=1, mem_we=latched we, mem_addr/mem_data = latched values.
//   - Write: go to RESP. Read: go to WAIT.
//  WAIT (MEM_LAT cycles, counter 0..MEM_LAT-1):
//   - mem_en=0.
//   - On the last WAIT cycle, rdata <= mem_q. Then go to RESP.
//  RESP (1 cycle):
//   - done[idx]=1. rdata is held (it is the last read value after a write).
//   - rr_ptr <= (idx+1) mod N_CORES. gnt cleared. Go to IDLE.
//  Latency from request seen in IDLE at cycle t:
//   - write: done at t+2.
//   - read: done at t+2+MEM_LAT.
//  Throughput: one access per 3 (write) or 3+MEM_LAT (read) cycles.
//  Request rules:
//   - req, req_we, req_addr and req_data are captured only in IDLE; later changes are ignored.
//   - req still high in the IDLE cycle after RESP counts as a new request. Requesters drop req on done.
//  Boundary cases:
//   - en[i] falling mid-transaction does not abort the transaction; done still pulses.
//   - Single requester: served back-to-back, no idle penalty beyond IDLE.
//   - rr_ptr wraps N_CORES-1 -> 0.
//   - All-disabled mask: stays in IDLE, busy=0.
//   - busy = (state!=IDLE) | (|(req & en)).
// STRUCTURE
//  Shared header sm_mem_defs.vh:
//   - FSM state encodings (2-bit).
//   - Defaults for N_CORES, AW, DW and MEM_LAT, consistent with the SP-core array.
//  Sub-module rr_pick:
//   - Combinational rotate-priority find-first-set.
//   - Inputs cand[N] and ptr. Outputs idx and valid.
//   - Reusable by other SM arbiters.
// TESTING
//  1) Reset held low 5 cycles, with req=8'hFF at release -> all outputs 0 during reset.
//     First grant is core0, gnt=8'h01 at cycle 1 after release.
//  2) Core3 writes addr 16'h0040 / data 16'hBEEF, then reads 16'h0040 (MEM_LAT=1).
//     -> write done 2 cycles after accept; read done 3 cycles after accept with rdata=16'hBEEF.
//  3) req=8'hFF held, all writes -> done order 0,1,...,7,0. Exactly one gnt bit high.
//     Each done is 3 cycles apart.
//  4) en=8'h0F, req=8'hFF -> only cores 0..3 granted; cores 4..7 never get done.
//     busy=1 while requests pending.
//  5) Reset asserted during WAIT of a core5 read -> mem_en, gnt and done drop to 0 immediately.
//     No done[5]. Next grant after release is core0.
//  6) MEM_LAT=3 build, core7 read with mem_q model returning 16'h1234 -> done[7] exactly 5 cycles after accept.
//     rdata=16'h1234 and mem_en high exactly 1 cycle.

Source files
------------

// File: rtl/sm_mem_arbiter_pkg.sv
// Shared types and defaults for the SM data-memory arbiter.
// The defaults match the SP-core array: 8 cores, 16-bit address and data, 1-cycle memory.
package sm_mem_arbiter_pkg;

    localparam int unsigned DEF_N_CORES = 8;
    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_MEM_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Index width that stays at least 1 bit for degenerate counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_mem_arbiter_if.sv
// Core-array and memory-macro signals of the SM memory arbiter.
// The slave modport is the arbiter's view; the master modport is the cores-plus-memory side.
interface sm_mem_arbiter_if
    import sm_mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CORES = DEF_N_CORES,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW
);
    logic [N_CORES-1:0]    en;
    logic [N_CORES-1:0]    req;
    logic [N_CORES-1:0]    req_we;
    logic [N_CORES*AW-1:0] req_addr;
    logic [N_CORES*DW-1:0] req_data;
    logic [N_CORES-1:0]    gnt;
    logic [N_CORES-1:0]    done;
    logic [DW-1:0]         rdata;
    logic                  busy;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_data;
    logic [DW-1:0]         mem_q;

    modport slave (
        input  en, req, req_we, req_addr, req_data, mem_q,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_data
    );

    modport master (
        output en, req, req_we, req_addr, req_data, mem_q,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/sm_mem_arbiter_rr_pick.sv
// Rotate-priority find-first-set: first set bit of cand searching up from ptr, wrapping.
// Purely combinational so other SM arbiters can reuse it.
module sm_mem_arbiter_rr_pick
    import sm_mem_arbiter_pkg::*;
#(
    parameter  int unsigned N  = DEF_N_CORES,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int unsigned j;
        j     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!valid && cand[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sm_mem_arbiter.sv
// Round-robin arbiter serialising SP-core accesses onto one single-port SM data memory.
// Each access runs IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> RESP.
module sm_mem_arbiter
    import sm_mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CORES = DEF_N_CORES,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic             clk,
    input  logic             reset,
    sm_mem_arbiter_if.slave  bus
);

    localparam int unsigned IW = idx_w(N_CORES);
    localparam int unsigned CW = idx_w(MEM_LAT);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_CORES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    state_e             state_q,    state_d;
    logic [IW-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [IW-1:0]      idx_q,      idx_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [N_CORES-1:0] gnt_q,      gnt_d;
    logic [N_CORES-1:0] done_q,     done_d;
    logic [DW-1:0]      rdata_q,    rdata_d;
    logic               mem_en_q,   mem_en_d;
    logic               mem_we_q,   mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_data_q, mem_data_d;

    logic [N_CORES-1:0] cand;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    assign cand = bus.req & bus.en;

    sm_mem_arbiter_rr_pick #(.N(N_CORES)) u_pick (
        .cand  (cand),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Outputs are computed one state ahead so they are valid in the state they belong to.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    mem_en_d        = 1'b1;
                    mem_we_d        = bus.req_we[pick_idx];
                    mem_addr_d      = bus.req_addr[32'(pick_idx) * AW +: AW];
                    mem_data_d      = bus.req_data[32'(pick_idx) * DW +: DW];
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // mem_we_q still holds the latched direction during ISSUE.
                if (mem_we_q) begin
                    done_d  = gnt_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rdata_d = bus.mem_q;
                    done_d  = gnt_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                gnt_d    = '0;
                rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = reset & ((state_q != ST_IDLE) | (|cand));

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed bench for sm_mem_arbiter: a MEM_LAT=1 instance with a RAM model and a
// MEM_LAT=3 instance whose memory answers 16'h1234 exactly three cycles after a read strobe.
module tb_sm_mem_arbiter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sm_mem_arbiter_if #(.N_CORES(8), .AW(16), .DW(16)) bus1 ();
    sm_mem_arbiter_if #(.N_CORES(8), .AW(16), .DW(16)) bus3 ();

    sm_mem_arbiter #(.N_CORES(8), .AW(16), .DW(16), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus1)
    );

    sm_mem_arbiter #(.N_CORES(8), .AW(16), .DW(16), .MEM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one-cycle read latency
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (bus1.mem_en) begin
            if (bus1.mem_we) mem[bus1.mem_addr[7:0]] <= bus1.mem_data;
            else             bus1.mem_q <= mem[bus1.mem_addr[7:0]];
        end
    end

    // Three-cycle read-latency model for the second instance
    logic [2:0] rd_pipe;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= 3'b000;
        else          rd_pipe <= {rd_pipe[1:0], bus3.mem_en & ~bus3.mem_we};
    end
    assign bus3.mem_q = rd_pipe[2] ? 16'h1234 : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] oh;
        int slot;
        int ph;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // 1) reset held with every core requesting a write
        reset_n     = 1'b0;
        bus1.en     = 8'hFF;
        bus1.req    = 8'hFF;
        bus1.req_we = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus1.req_addr[i*16 +: 16] = 16'h0100 + 16'(i);
            bus1.req_data[i*16 +: 16] = 16'hD000 + 16'(i);
        end
        bus3.en       = 8'h00;
        bus3.req      = 8'h00;
        bus3.req_we   = 8'h00;
        bus3.req_addr = '0;
        bus3.req_data = '0;
        repeat (5) begin
            tick();
            check("rst_gnt",   64'(bus1.gnt),      64'h0);
            check("rst_done",  64'(bus1.done),     64'h0);
            check("rst_mem_en",64'(bus1.mem_en),   64'h0);
            check("rst_busy",  64'(bus1.busy),     64'h0);
        end
        check("rst_rdata",    64'(bus1.rdata),    64'h0);
        check("rst_mem_addr", 64'(bus1.mem_addr), 64'h0);
        check("rst_mem_data", 64'(bus1.mem_data), 64'h0);
        check("rst_mem_we",   64'(bus1.mem_we),   64'h0);
        reset_n = 1'b1;

        // 1)+3) all cores write: slot k wins core k%8, ISSUE/RESP/IDLE per slot
        for (int c = 1; c <= 27; c++) begin
            tick();
            slot = (c - 1) / 3;
            ph   = (c - 1) % 3;
            oh   = 8'(1) << (slot % 8);
            check("rr_gnt",    64'(bus1.gnt),    (ph == 2) ? 64'h0 : 64'(oh));
            check("rr_done",   64'(bus1.done),   (ph == 1) ? 64'(oh) : 64'h0);
            check("rr_mem_en", 64'(bus1.mem_en), (ph == 0) ? 64'h1 : 64'h0);
            if (ph == 0) check("rr_mem_addr", 64'(bus1.mem_addr), 64'(16'h0100 + 16'(slot % 8)));
        end
        bus1.req = 8'h00;
        tick();
        check("idle_busy", 64'(bus1.busy), 64'h0);
        check("idle_gnt",  64'(bus1.gnt),  64'h0);

        // 2) core3 write then read of the same address
        bus1.req              = 8'h08;
        bus1.req_we           = 8'h08;
        bus1.req_addr[48 +: 16] = 16'h0040;
        bus1.req_data[48 +: 16] = 16'hBEEF;
        #1;
        check("wr_busy_req", 64'(bus1.busy), 64'h1);
        tick();
        check("wr_gnt",      64'(bus1.gnt),      64'h08);
        check("wr_mem_en",   64'(bus1.mem_en),   64'h1);
        check("wr_mem_we",   64'(bus1.mem_we),   64'h1);
        check("wr_mem_addr", 64'(bus1.mem_addr), 64'h0040);
        check("wr_mem_data", 64'(bus1.mem_data), 64'hBEEF);
        tick();
        check("wr_done",     64'(bus1.done),     64'h08);
        check("wr_rdata_hold", 64'(bus1.rdata),  64'h0);
        bus1.req_we = 8'h00;
        tick();
        check("rd_idle_gnt", 64'(bus1.gnt),      64'h0);
        check("rd_idle_done",64'(bus1.done),     64'h0);
        tick();
        check("rd_gnt",      64'(bus1.gnt),      64'h08);
        check("rd_mem_en",   64'(bus1.mem_en),   64'h1);
        check("rd_mem_we",   64'(bus1.mem_we),   64'h0);
        check("rd_mem_addr", 64'(bus1.mem_addr), 64'h0040);
        tick();
        check("rd_wait_en",  64'(bus1.mem_en),   64'h0);
        check("rd_wait_done",64'(bus1.done),     64'h0);
        tick();
        check("rd_done",     64'(bus1.done),     64'h08);
        check("rd_rdata",    64'(bus1.rdata),    64'hBEEF);
        bus1.req = 8'h00;
        tick();

        // 4) only cores 0..3 enabled; pointer is at 4 so the search wraps to core0
        bus1.en     = 8'h0F;
        bus1.req    = 8'hFF;
        bus1.req_we = 8'hFF;
        #1;
        check("en_busy", 64'(bus1.busy), 64'h1);
        for (int s = 0; s < 4; s++) begin
            oh = 8'(1) << s;
            tick();
            check("en_gnt",  64'(bus1.gnt),  64'(oh));
            tick();
            check("en_done", 64'(bus1.done), 64'(oh));
            tick();
            check("en_idle_done", 64'(bus1.done), 64'h0);
            check("en_idle_busy", 64'(bus1.busy), 64'h1);
        end
        bus1.req = 8'h00;
        tick();

        // en falling mid-transaction does not abort it
        bus1.en  = 8'h20;
        bus1.req = 8'h20;
        tick();
        check("enfall_gnt", 64'(bus1.gnt), 64'h20);
        bus1.en = 8'h00;
        #1;
        check("enfall_busy", 64'(bus1.busy), 64'h1);
        tick();
        check("enfall_done", 64'(bus1.done), 64'h20);
        bus1.req = 8'h00;
        tick();

        // all-disabled mask never grants
        bus1.req = 8'hFF;
        #1;
        check("dis_busy0", 64'(bus1.busy), 64'h0);
        repeat (2) begin
            tick();
            check("dis_gnt",    64'(bus1.gnt),    64'h0);
            check("dis_mem_en", 64'(bus1.mem_en), 64'h0);
            check("dis_busy",   64'(bus1.busy),   64'h0);
        end

        // 5) reset during the WAIT of a core5 read
        bus1.en     = 8'hFF;
        bus1.req    = 8'h20;
        bus1.req_we = 8'h00;
        tick();
        check("r5_gnt",    64'(bus1.gnt),    64'h20);
        check("r5_mem_en", 64'(bus1.mem_en), 64'h1);
        tick();
        check("r5_wait_gnt", 64'(bus1.gnt), 64'h20);
        reset_n  = 1'b0;
        bus1.req = 8'h21;
        #1;
        check("r5_rst_gnt",    64'(bus1.gnt),    64'h0);
        check("r5_rst_done",   64'(bus1.done),   64'h0);
        check("r5_rst_mem_en", 64'(bus1.mem_en), 64'h0);
        check("r5_rst_busy",   64'(bus1.busy),   64'h0);
        repeat (2) begin
            tick();
            check("r5_hold_done", 64'(bus1.done), 64'h0);
        end
        reset_n = 1'b1;
        tick();
        check("r5_post_gnt", 64'(bus1.gnt), 64'h01);
        bus1.req = 8'h00;
        tick();
        check("r5_post_wait_done", 64'(bus1.done), 64'h0);
        tick();
        check("r5_post_done", 64'(bus1.done), 64'h01);
        tick();

        // 6) MEM_LAT=3 instance, core7 read
        bus3.en               = 8'h80;
        bus3.req              = 8'h80;
        bus3.req_addr[112 +: 16] = 16'h0077;
        #1;
        check("l3_busy", 64'(bus3.busy), 64'h1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus3.req = 8'h00;
            check("l3_mem_en", 64'(bus3.mem_en), (c == 1) ? 64'h1 : 64'h0);
            check("l3_done",   64'(bus3.done),   (c == 5) ? 64'h80 : 64'h0);
            check("l3_gnt",    64'(bus3.gnt),    (c <= 5) ? 64'h80 : 64'h0);
        end
        check("l3_rdata", 64'(bus3.rdata), 64'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
